// File: rtl/hangman_pkg.sv
// Shared types and constants for the hangman UART transmit path.
package hangman_pkg;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StSend     = 2'd1,
    StWaitAck  = 2'd2,
    StWaitDone = 2'd3
  } tx_sched_state_t;

  localparam logic [7:0] ASCII_A          = 8'h41;
  localparam logic [7:0] ASCII_Z          = 8'h5A;
  localparam logic [7:0] END_CODE_DEFAULT = 8'h04;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_A) && (c <= ASCII_Z);
  endfunction

endpackage

// File: rtl/hangman_tx_scheduler_if.sv
// Keypad/game-end inputs and UART transmitter handshake of the tx scheduler.
interface hangman_tx_scheduler_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  logic              letter_valid;
  logic [7:0]        letter_data;
  logic              game_end;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              tx_clk;
  logic              busy;
  logic              overflow;
  logic [CountW-1:0] fifo_count;

  // Scheduler side.
  modport master (
    input  letter_valid, letter_data, game_end, tx_ready,
    output tx_data, tx_clk, busy, overflow, fifo_count
  );

  // Keypad FSM / transmitter side.
  modport slave (
    output letter_valid, letter_data, game_end, tx_ready,
    input  tx_data, tx_clk, busy, overflow, fifo_count
  );
endinterface

// File: rtl/hangman_tx_scheduler_byte_fifo.sv
// Byte FIFO with combinational head, flush, and push accepted on full when popping.
module byte_fifo #(
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned PtrW   = $clog2(DEPTH),
  localparam int unsigned CountW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              nRst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [7:0]        din,
  output logic [7:0]        dout,
  output logic [CountW-1:0] count,
  output logic              full,
  output logic              empty
);
  logic [7:0]        mem_q [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [CountW-1:0] count_q;
  logic              do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CountW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_q <= count_q + CountW'(1);
      else if (!do_push && do_pop) count_q <= count_q - CountW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= din;
  end
endmodule

// File: rtl/hangman_tx_scheduler.sv
// Queues keypad letters and the game-end code onto the single UART transmitter.
module hangman_tx_scheduler
  import hangman_pkg::*;
#(
  parameter int unsigned DEPTH       = 4,
  parameter logic [7:0]  END_CODE    = END_CODE_DEFAULT,
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input logic                    clk,
  input logic                    nRst,
  hangman_tx_scheduler_if.master bus
);
  localparam int unsigned CountW = $clog2(DEPTH + 1);
  localparam int unsigned AckW   = $clog2(ACK_TIMEOUT + 1);

  tx_sched_state_t   state_q, state_d;
  logic [7:0]        tx_data_q, head;
  logic              end_pending_q, overflow_q;
  logic [AckW-1:0]   ack_cnt_q;
  logic [CountW-1:0] count;
  logic              full, empty, push, pop, load, load_end, tx_clk, ack_expired;

  // A letter arriving with game_end is dropped along with the flushed queue.
  assign push        = bus.letter_valid && is_upper(bus.letter_data) && !bus.game_end;
  assign pop         = load && !load_end;
  assign ack_expired = (ack_cnt_q == AckW'(ACK_TIMEOUT - 1));

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .nRst (nRst),
    .push (push),
    .pop  (pop),
    .flush(bus.game_end),
    .din  (bus.letter_data),
    .dout (head),
    .count(count),
    .full (full),
    .empty(empty)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:     if (bus.tx_ready && (end_pending_q || !empty)) state_d = StSend;
      StSend:     state_d = StWaitAck;
      StWaitAck: begin
        if (!bus.tx_ready)    state_d = StWaitDone;
        else if (ack_expired) state_d = StIdle;
      end
      StWaitDone: if (bus.tx_ready) state_d = StIdle;
      default:    state_d = StIdle;
    endcase
  end

  always_comb begin
    load     = 1'b0;
    load_end = 1'b0;
    tx_clk   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.tx_ready && (end_pending_q || !empty)) begin
          load     = 1'b1;
          load_end = end_pending_q;
        end
      end
      StSend:  tx_clk = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      tx_data_q     <= 8'h00;
      end_pending_q <= 1'b0;
      overflow_q    <= 1'b0;
      ack_cnt_q     <= '0;
    end else begin
      if (load) tx_data_q <= load_end ? END_CODE : head;

      if (bus.game_end)  end_pending_q <= 1'b1;
      else if (load_end) end_pending_q <= 1'b0;

      if (bus.game_end)              overflow_q <= 1'b0;
      else if (push && full && !pop) overflow_q <= 1'b1;

      // Counts only cycles in WAIT_ACK with the transmitter still idle.
      if (state_q == StWaitAck && bus.tx_ready) ack_cnt_q <= ack_cnt_q + AckW'(1);
      else                                      ack_cnt_q <= '0;
    end
  end

  assign bus.tx_data    = tx_data_q;
  assign bus.tx_clk     = tx_clk;
  assign bus.busy       = (state_q != StIdle) || !empty || end_pending_q;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_hangman_tx_scheduler.sv
// Scoreboard bench for hangman_tx_scheduler with a simple UART transmitter model.
module tb_hangman_tx_scheduler;
  logic clk  = 1'b0;
  logic nRst = 1'b1;
  always #5 clk = ~clk;

  hangman_tx_scheduler_if #(.DEPTH(4)) bus ();

  hangman_tx_scheduler #(
    .DEPTH      (4),
    .END_CODE   (8'h04),
    .ACK_TIMEOUT(8)
  ) dut (
    .clk (clk),
    .nRst(nRst),
    .bus (bus)
  );

  // -1 in a field means "don't check".
  typedef struct {
    string name;
    int    cnt;
    int    ovf;
    int    busy;
    int    txclk;
    int    data;
  } stat_t;

  stat_t      stat_q[$];
  logic [7:0] sb_q[$];
  int         checks   = 0;
  int         failures = 0;
  bit         done     = 0;
  bit         hold_low = 0;
  bit         no_ack   = 0;
  int         ack_left = 0;

  // Transmitter: goes busy for 3 cycles after each strobe unless told to ignore it.
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.tx_clk && !no_ack) ack_left = 3;
      else if (ack_left > 0)     ack_left--;
      bus.tx_ready = !hold_low && (ack_left == 0);
    end
  end

  function automatic void cmp(string name, string field, int got, int exp);
    if (exp < 0) return;
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s.%s got=%0h expected=%0h", name, field, got, exp);
    end
  endfunction

  // Monitor: pops status expectations and scoreboard bytes on every strobe.
  always @(negedge clk) begin
    stat_t      s;
    logic [7:0] exp_b;
    while (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      cmp(s.name, "fifo_count", int'(bus.fifo_count), s.cnt);
      cmp(s.name, "overflow",   int'(bus.overflow),   s.ovf);
      cmp(s.name, "busy",       int'(bus.busy),       s.busy);
      cmp(s.name, "tx_clk",     int'(bus.tx_clk),     s.txclk);
      cmp(s.name, "tx_data",    int'(bus.tx_data),    s.data);
    end
    if (bus.tx_clk === 1'b1) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_strobe got tx_data=%02h expected no strobe", bus.tx_data);
      end else begin
        exp_b = sb_q.pop_front();
        if (bus.tx_data !== exp_b) begin
          failures++;
          $display("FAIL strobe_byte got=%02h expected=%02h", bus.tx_data, exp_b);
        end
      end
    end
    if (done) begin
      checks++;
      if (sb_q.size() != 0) begin
        failures++;
        $display("FAIL sb_drain got=%0d pending expected=0", sb_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_stat(string n, int cnt, int ovf, int busy, int txclk, int data);
    stat_t s;
    s.name  = n;
    s.cnt   = cnt;
    s.ovf   = ovf;
    s.busy  = busy;
    s.txclk = txclk;
    s.data  = data;
    stat_q.push_back(s);
  endtask

  // Bounded wait; an expired bound shows up as a busy=1 failure.
  task automatic wait_idle(string n);
    for (int i = 0; i < 60 && bus.busy; i++) step();
    expect_stat(n, 0, -1, 0, 0, -1);
  endtask

  task automatic letter(logic [7:0] d, bit expected_sent);
    bus.letter_valid = 1'b1;
    bus.letter_data  = d;
    if (expected_sent) sb_q.push_back(d);
  endtask

  initial begin
    bus.letter_valid = 1'b0;
    bus.letter_data  = 8'h00;
    bus.game_end     = 1'b0;
    #1 nRst = 1'b0;
    step();
    expect_stat("reset", 0, 0, 0, 0, 8'h00);
    step();
    nRst = 1'b1;
    step();

    // Single letter: strobe two cycles after submission.
    letter(8'h48, 1);
    step(); bus.letter_valid = 1'b0;
    expect_stat("t1_enq", 1, 0, 1, 0, 8'h00);
    step();
    expect_stat("t1_strobe", 0, 0, 1, 1, 8'h48);
    wait_idle("t1_idle");

    // Filter: out-of-range bytes including the 'A'..'Z' neighbours.
    letter(8'h00, 0); step();
    letter(8'h61, 0); step();
    letter(8'h40, 0); step();
    letter(8'h5B, 0); step();
    bus.letter_valid = 1'b0;
    expect_stat("t3_filter", 0, 0, 0, 0, 8'h48);
    step(); step();
    expect_stat("t3_quiet", 0, 0, 0, 0, 8'h48);

    // Overflow: five letters into four entries with the transmitter held busy.
    hold_low = 1; step(); step();
    for (int i = 0; i < 5; i++) begin
      letter(8'(8'h41 + i), i < 4);
      step();
    end
    bus.letter_valid = 1'b0;
    expect_stat("t2_full", 4, 1, 1, 0, 8'h48);
    hold_low = 0;
    wait_idle("t2_idle");
    expect_stat("t2_sticky", 0, 1, 0, -1, 8'h44);

    // game_end while the first of two letters is in WAIT_DONE.
    letter(8'h4B, 1); step();
    letter(8'h4C, 0); step();
    bus.letter_valid = 1'b0;
    expect_stat("t4_first_strobe", 1, 1, 1, 1, 8'h4B);
    step(); step();
    bus.game_end = 1'b1; step();
    bus.game_end = 1'b0; sb_q.push_back(8'h04);
    expect_stat("t4_flushed", 0, 0, 1, 0, 8'h4B);
    wait_idle("t4_idle");

    // Letter and game_end together from idle: only END_CODE goes out.
    letter(8'h4D, 0); bus.game_end = 1'b1; sb_q.push_back(8'h04);
    step();
    bus.letter_valid = 1'b0; bus.game_end = 1'b0;
    expect_stat("t5_pending", 0, 0, 1, 0, -1);
    step();
    expect_stat("t5_strobe", 0, 0, 1, 1, 8'h04);
    wait_idle("t5_idle");

    // Transmitter never acknowledges: 8 cycles in WAIT_ACK, then the next byte.
    no_ack = 1;
    letter(8'h5A, 1); step();
    letter(8'h41, 1); step();
    bus.letter_valid = 1'b0;
    expect_stat("t6_strobe", 1, 0, 1, 1, 8'h5A);
    repeat (8) step();
    expect_stat("t6_waitack_last", 1, 0, 1, 0, 8'h5A);
    step();
    expect_stat("t6_idle_gap", 1, 0, 1, 0, 8'h5A);
    step();
    expect_stat("t6_second", 0, 0, 1, 1, 8'h41);
    wait_idle("t6_idle");
    no_ack = 0;

    // Reset in WAIT_DONE with three letters queued.
    letter(8'h52, 1); step();
    letter(8'h53, 0); step();
    letter(8'h54, 0); step();
    letter(8'h55, 0);
    expect_stat("t7_queue", 2, 0, 1, 0, 8'h52);
    step();
    bus.letter_valid = 1'b0;
    nRst = 1'b0;
    #1;
    expect_stat("t7_reset", 0, 0, 0, 0, 8'h00);
    step(); step(); step();
    nRst = 1'b1;
    repeat (10) step();
    expect_stat("t7_after", 0, 0, 0, 0, 8'h00);
    step();
    done = 1;
  end
endmodule

// File: doc/hangman_tx_scheduler.md
# hangman_tx_scheduler

- Sequences outbound game traffic onto the single UART transmitter.
- Takes submitted letters from the keypad FSM (`ready`/`data` pulse) and the game-end pulse.
- Buffers letters in a small FIFO and arbitrates them against the end-of-game message.
- Drives the transmitter load handshake; sits between the keypad FSM and the top-level UART `txdata`/`txclk`/`txready` ports.

## Interface
- DEPTH, 4: letter FIFO entries; power of two, ≥2.
- END_CODE, 8'h04: byte sent on game end.
- ACK_TIMEOUT, 8: cycles to wait for `tx_ready` to fall after a load before treating the byte as sent.
- clk  input  1  system clock (hz100 at top).
- nRst  input  1  asynchronous, active-low reset.
- letter_valid  input  1  one-cycle pulse: letter submitted.
- letter_data  input  8  ASCII letter, sampled when `letter_valid`=1.
- game_end  input  1  one-cycle pulse: game over.
- tx_ready  input  1  transmitter idle; low while shifting a byte.
- tx_data  output  8  byte presented to the transmitter.
- tx_clk  output  1  one-cycle load strobe; `tx_data` is valid while it is high.
- busy  output  1  high in any state other than IDLE, or while the FIFO is non-empty, or while the end flag is pending.
- overflow  output  1  sticky: a valid letter was dropped because the FIFO was full.
- fifo_count  output  $clog2(DEPTH+1)  letters queued.

## Operation
- **Letter filter:** only `letter_data` in 8'h41..8'h5A ('A'..'Z') is enqueued. Other values, including 8'h00, are silently discarded and do not set `overflow`.
- **Game end:**
  - `game_end` sets `end_pending`, flushes the FIFO (`fifo_count`→0) and clears `overflow`.
  - A letter pulse in the same cycle as `game_end` is discarded.
- **Push when full:**
  - With a simultaneous pop, the push is accepted and the count is unchanged.
  - Otherwise the letter is dropped and `overflow` is set.
- **FSM** (registered state):
  - IDLE → SEND when `tx_ready`=1 and (`end_pending` or `fifo_count`≠0).
    - If `end_pending`, load END_CODE and clear `end_pending`; `end_pending` has priority over the FIFO.
    - Otherwise pop the FIFO head into the `tx_data` register.
  - SEND: `tx_clk`=1 for exactly this one cycle; always → WAIT_ACK.
  - WAIT_ACK: → WAIT_DONE when `tx_ready`=0; → IDLE once ACK_TIMEOUT cycles elapse with `tx_ready` high.
  - WAIT_DONE: → IDLE when `tx_ready`=1.
- `game_end` during SEND/WAIT_*: the byte in flight completes, then END_CODE is sent next.
- `tx_data` holds its last loaded value until the next load.

## Timing
- **Reset values:** state IDLE, `tx_data`=8'h00, `tx_clk`=0, `busy`=0, `overflow`=0, `fifo_count`=0, `end_pending`=0.
- **Reset mid-transfer:** asserting `nRst` mid-transfer aborts immediately to the reset values; the queue is lost.
- **Latency (idle, FIFO empty, `tx_ready`=1):** `letter_valid` in cycle t → `fifo_count`=1 in t+1 → `tx_clk`=1 and `tx_data`=letter in t+2, with `fifo_count`=0 in t+2.
- `game_end` has the same 2-cycle latency to the END_CODE strobe.
- **Back-to-back bytes:** minimum spacing is SEND + 1 WAIT_ACK + 1 WAIT_DONE + IDLE, i.e. 4 cycles strobe-to-strobe with an ideal transmitter.
- `overflow` rises the cycle after the dropping push.

## Structure
- **`hangman_pkg`:**
  - `tx_sched_state_t` enum (IDLE=0, SEND=1, WAIT_ACK=2, WAIT_DONE=3).
  - Constants ASCII_A=8'h41, ASCII_Z=8'h5A, default END_CODE.
- **Sub-module `byte_fifo`** (DEPTH parameter):
  - Ports: push, pop, flush, din, dout (head, combinational), count, full, empty.
  - Simultaneous push+pop is allowed when full.
- The ACK timeout counter, filter and arbitration live in `hangman_tx_scheduler`.

## Test plan
- Reset, then one letter 8'h48 with `tx_ready` held 1; transmitter model drops `tx_ready` for 3 cycles after the strobe → `tx_clk` pulse at t+2 with `tx_data`=8'h48, `busy` low after `tx_ready` returns.
- Five letters A,B,C,D,E pushed on consecutive cycles while `tx_ready`=0 (DEPTH=4) → `fifo_count`=4, `overflow`=1. On release, `tx_data` sequence is 41,42,43,44 and E is never sent.
- `letter_valid` with 8'h00 and 8'h61 → nothing enqueued, `overflow`=0, no `tx_clk`.
- Queue 2 letters, then `game_end` while the first is in WAIT_DONE:
  - the first letter completes, the second is flushed, next strobe carries 8'h04;
  - `overflow` is cleared.
- `letter_valid` and `game_end` in the same cycle from idle → only 8'h04 sent.
- `tx_ready` never falls after a strobe → return to IDLE after 8 cycles in WAIT_ACK; next queued byte then strobes.
- `nRst` pulsed low during WAIT_DONE with 3 queued → all outputs at reset values immediately, no further `tx_clk`.
